// File: rtl/i2s_dds_source_if.sv
// Control and sample bus between the DDS tone source and its consumer.
interface i2s_dds_source_if #(
  parameter int unsigned PHASE_W = 32
);
  logic [PHASE_W-1:0] fcw_l;
  logic [PHASE_W-1:0] fcw_r;
  logic               fcw_load;
  logic               phase_clr;
  logic [7:0]         amp;
  logic [15:0]        l_din;
  logic [15:0]        r_din;
  logic               l_en;
  logic               r_en;
  logic               frame_sync;

  modport master (
    output fcw_l, fcw_r, fcw_load, phase_clr, amp,
    input  l_din, r_din, l_en, r_en, frame_sync
  );

  modport slave (
    input  fcw_l, fcw_r, fcw_load, phase_clr, amp,
    output l_din, r_din, l_en, r_en, frame_sync
  );
endinterface

// File: rtl/i2s_dds_source.sv
// Dual-channel DDS sine source feeding an I2S transmitter. One sample per channel per frame,
// left triggered at cnt 0, right at cnt FRAME_DIV/2, through a shared 4-stage pipeline.
module i2s_dds_source #(
  parameter int unsigned FRAME_DIV = 512,
  parameter int unsigned PHASE_W   = 32
) (
  input logic             mclk,
  input logic             rst_n,
  i2s_dds_source_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(FRAME_DIV);
  localparam logic [CntW-1:0] CntHalf = CntW'(FRAME_DIV / 2);
  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_DIV - 1);
  // pi/2 in Q60 fixed point
  localparam logic signed [127:0] HalfPiQ60 = 128'sh1921_FB54_442D_1846;

  // Quarter-wave entry: round(32767 * sin(pi/2 * (idx + 0.5) / 256)), Taylor series in Q60.
  function automatic logic [14:0] lut_entry(input int unsigned idx);
    logic signed [127:0] x, x2, term, sum, den;
    x  = 128'(2 * idx + 1);
    x  = (x * HalfPiQ60) >>> 9;
    x2 = (x * x) >>> 60;
    term = x;
    sum  = x;
    for (int k = 1; k <= 9; k++) begin
      den  = 128'((2 * k) * (2 * k + 1));
      term = -((term * x2) >>> 60) / den;
      sum  = sum + term;
    end
    sum = (sum * 128'sd32767 + (128'sd1 <<< 59)) >>> 60;
    return 15'(sum);
  endfunction

  logic [14:0] lut [256];
  for (genvar i = 0; i < 256; i++) begin : g_lut
    localparam logic [14:0] Entry = lut_entry(i);
    assign lut[i] = Entry;
  end

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_l_q, phase_l_d, phase_r_q, phase_r_d;
  logic [PHASE_W-1:0] shd_l_q, shd_l_d, shd_r_q, shd_r_d;
  logic [PHASE_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic               clr_q, clr_d;
  logic               trig_l, trig_r, frame_end, clr_now;

  // Next state for the frame counter, phase accumulators, fcw shadowing and clear request
  always_comb begin
    trig_l    = (cnt_q == '0);
    trig_r    = (cnt_q == CntHalf);
    frame_end = (cnt_q == CntLast);
    clr_now   = clr_q | bus.phase_clr;
    cnt_d     = cnt_q + CntW'(1);
    phase_l_d = phase_l_q;
    phase_r_d = phase_r_q;
    shd_l_d   = shd_l_q;
    shd_r_d   = shd_r_q;
    act_l_d   = act_l_q;
    act_r_d   = act_r_q;
    clr_d     = clr_now;
    if (trig_l) phase_l_d = phase_l_q + act_l_q;
    if (trig_r) phase_r_d = phase_r_q + act_r_q;
    if (bus.fcw_load) begin
      shd_l_d = bus.fcw_l;
      shd_r_d = bus.fcw_r;
    end
    if (frame_end) begin
      // A load in the transfer cycle bypasses the shadow
      act_l_d = bus.fcw_load ? bus.fcw_l : shd_l_q;
      act_r_d = bus.fcw_load ? bus.fcw_r : shd_r_q;
      clr_d   = 1'b0;
      if (clr_now) begin
        phase_l_d = '0;
        phase_r_d = '0;
      end
    end
  end

  // Control state registers
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      phase_l_q <= '0;
      phase_r_q <= '0;
      shd_l_q   <= '0;
      shd_r_q   <= '0;
      act_l_q   <= '0;
      act_r_q   <= '0;
      clr_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      phase_l_q <= phase_l_d;
      phase_r_q <= phase_r_d;
      shd_l_q   <= shd_l_d;
      shd_r_q   <= shd_r_d;
      act_l_q   <= act_l_d;
      act_r_q   <= act_r_d;
      clr_q     <= clr_d;
    end
  end

  logic        s1_vld, s1_ch, s2_vld, s2_ch, s2_neg, s3_vld, s3_ch;
  logic [9:0]  s1_idx;
  logic [7:0]  s1_amp, s2_amp, s3_amp, rom_addr;
  logic [14:0] s2_mag;
  logic [15:0] s3_smp, scaled;
  logic [8:0]  gain;
  logic signed [24:0] prod;
  logic [15:0] l_din_q, r_din_q;
  logic        l_en_q, r_en_q, fs_q;

  // Odd quadrants read the table mirrored; the sign is applied one stage later
  assign rom_addr = s1_idx[8] ? ~s1_idx[7:0] : s1_idx[7:0];
  assign gain     = {1'b0, s3_amp} + 9'd1;
  assign prod     = $signed({{9{s3_smp[15]}}, s3_smp}) * $signed({16'd0, gain});
  assign scaled   = 16'(prod >>> 8);

  // Sample pipeline: index/amp capture, ROM read, mirror/negate, gain into output registers
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_ch   <= 1'b0;
      s1_idx  <= '0;
      s1_amp  <= '0;
      s2_vld  <= 1'b0;
      s2_ch   <= 1'b0;
      s2_neg  <= 1'b0;
      s2_mag  <= '0;
      s2_amp  <= '0;
      s3_vld  <= 1'b0;
      s3_ch   <= 1'b0;
      s3_smp  <= '0;
      s3_amp  <= '0;
      l_din_q <= '0;
      r_din_q <= '0;
      l_en_q  <= 1'b0;
      r_en_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      s1_vld  <= trig_l | trig_r;
      s1_ch   <= trig_r;
      s1_idx  <= trig_r ? phase_r_q[PHASE_W-1 -: 10] : phase_l_q[PHASE_W-1 -: 10];
      s1_amp  <= bus.amp;
      s2_vld  <= s1_vld;
      s2_ch   <= s1_ch;
      s2_neg  <= s1_idx[9];
      s2_mag  <= lut[rom_addr];
      s2_amp  <= s1_amp;
      s3_vld  <= s2_vld;
      s3_ch   <= s2_ch;
      s3_smp  <= s2_neg ? (16'd0 - {1'b0, s2_mag}) : {1'b0, s2_mag};
      s3_amp  <= s2_amp;
      l_en_q  <= s3_vld & ~s3_ch;
      r_en_q  <= s3_vld & s3_ch;
      if (s3_vld && !s3_ch) l_din_q <= scaled;
      if (s3_vld && s3_ch)  r_din_q <= scaled;
      // Registered so the pulse lines up with cnt == 0 of each wrapped frame
      fs_q    <= frame_end;
    end
  end

  assign bus.l_din      = l_din_q;
  assign bus.r_din      = r_din_q;
  assign bus.l_en       = l_en_q;
  assign bus.r_en       = r_en_q;
  assign bus.frame_sync = fs_q;

endmodule

// File: tb/tb_i2s_dds_source.sv
// Scoreboard bench for i2s_dds_source: a frame-level reference model pushes expected samples,
// a monitor pops them whenever a strobe is due or seen.
module tb_i2s_dds_source;

  localparam int unsigned FD = 512;
  localparam int unsigned PW = 32;
  localparam real         PI = 3.14159265358979323846;

  typedef struct {
    bit ch;
    int cnt;
    int val;
  } exp_t;

  logic mclk = 1'b0;
  logic rst_n;

  i2s_dds_source_if #(.PHASE_W(PW)) bus ();

  i2s_dds_source #(.FRAME_DIV(FD), .PHASE_W(PW)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 mclk = ~mclk;

  int      n_chk;
  int      n_fail;
  int      m_cnt;
  bit      m_wrapped;
  bit      m_clr;
  bit [31:0] m_phase [2];
  bit [31:0] m_act [2];
  bit [31:0] m_shd [2];
  int      last_val [2];
  exp_t    exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cnt %0d, t=%0t)", name, act, exp, m_cnt, $time);
    end
  endtask

  function automatic int lut_ref(input int a);
    real r;
    r = 32767.0 * $sin(PI / 2.0 * (real'(a) + 0.5) / 256.0);
    return $rtoi(r + 0.5);
  endfunction

  // Sine of the top 10 phase bits, scaled by (amp+1)/256 with floor
  function automatic int sample_ref(input bit [31:0] ph, input int amp);
    int idx, q, a, m, s;
    idx = int'(ph[31:22]);
    q   = idx / 256;
    a   = idx % 256;
    m   = (q % 2 == 1) ? lut_ref(255 - a) : lut_ref(a);
    s   = (q >= 2) ? -m : m;
    return $rtoi($floor(real'(s * (amp + 1)) / 256.0));
  endfunction

  task automatic push_sample(input int ch);
    exp_t e;
    e.ch  = (ch == 1);
    e.cnt = (m_cnt + 4) % FD;
    e.val = sample_ref(m_phase[ch], int'(bus.amp));
    exp_q.push_back(e);
    m_phase[ch] = m_phase[ch] + m_act[ch];
  endtask

  // Reference behaviour for the upcoming rising edge, given current inputs and m_cnt
  task automatic model_edge();
    if (m_cnt == 0) push_sample(0);
    if (m_cnt == FD / 2) push_sample(1);
    if (m_cnt == FD - 1) begin
      if (m_clr || bus.phase_clr) begin
        m_phase[0] = '0;
        m_phase[1] = '0;
      end
      m_clr     = 1'b0;
      m_act[0]  = bus.fcw_load ? bus.fcw_l : m_shd[0];
      m_act[1]  = bus.fcw_load ? bus.fcw_r : m_shd[1];
      m_wrapped = 1'b1;
    end else if (bus.phase_clr) begin
      m_clr = 1'b1;
    end
    if (bus.fcw_load) begin
      m_shd[0] = bus.fcw_l;
      m_shd[1] = bus.fcw_r;
    end
    m_cnt = (m_cnt + 1) % FD;
  endtask

  task automatic reset_model();
    m_cnt     = 0;
    m_wrapped = 1'b0;
    m_clr     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_phase[i]  = '0;
      m_act[i]    = '0;
      m_shd[i]    = '0;
      last_val[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic step();
    model_edge();
    @(posedge mclk);
    @(negedge mclk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wait_cnt(input int c);
    while (m_cnt != c) step();
  endtask

  task automatic pulse_load();
    bus.fcw_load = 1'b1;
    step();
    bus.fcw_load = 1'b0;
  endtask

  task automatic check_zero_outputs();
    chk("rst_l_din", int'(bus.l_din), 0);
    chk("rst_r_din", int'(bus.r_din), 0);
    chk("rst_l_en", int'(bus.l_en), 0);
    chk("rst_r_en", int'(bus.r_en), 0);
    chk("rst_frame_sync", int'(bus.frame_sync), 0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock edge
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    check_zero_outputs();
    reset_model();
    repeat (2) begin
      @(posedge mclk);
      @(negedge mclk);
    end
    rst_n = 1'b1;
  endtask

  // Monitor: compare strobes and held sample values each cycle, away from the clock edge
  initial begin : monitor
    exp_t e;
    bit   due;
    bit   en;
    int   din;
    forever begin
      @(posedge mclk);
      #2;
      chk("strobe_overlap", int'(bus.l_en & bus.r_en), 0);
      for (int ch = 0; ch < 2; ch++) begin
        en  = (ch == 0) ? bus.l_en : bus.r_en;
        din = (ch == 0) ? int'($signed(bus.l_din)) : int'($signed(bus.r_din));
        due = (exp_q.size() > 0) && (int'(exp_q[0].ch) == ch) && (exp_q[0].cnt == m_cnt);
        if (en || due) begin
          chk((ch == 0) ? "l_en" : "r_en", int'(en), int'(due));
          if (due) begin
            e = exp_q.pop_front();
            last_val[ch] = e.val;
          end
        end
        chk((ch == 0) ? "l_din" : "r_din", din, last_val[ch]);
      end
      if (bus.frame_sync || (m_cnt == 0 && m_wrapped))
        chk("frame_sync", int'(bus.frame_sync), int'(m_cnt == 0 && m_wrapped));
    end
  end

  initial begin : driver
    n_chk         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.fcw_l     = '0;
    bus.fcw_r     = '0;
    bus.fcw_load  = 1'b0;
    bus.phase_clr = 1'b0;
    bus.amp       = 8'd255;
    reset_model();
    @(negedge mclk);
    @(negedge mclk);
    check_zero_outputs();
    rst_n = 1'b1;

    // DC at full gain: every sample is lut[0]
    idle(3 * FD);
    chk("dc_l_din", int'($signed(bus.l_din)), 101);
    chk("dc_r_din", int'($signed(bus.r_din)), 101);

    // Quarter-step tone, then half gain
    bus.fcw_l = 32'h4000_0000;
    bus.fcw_r = 32'h2000_0000;
    pulse_load();
    idle(5 * FD);
    bus.amp = 8'd127;
    idle(4 * FD);

    // Mid-frame load of a new right word
    wait_cnt(300);
    bus.fcw_r = 32'h1000_0000;
    pulse_load();
    idle(2 * FD);

    // Load in the transfer cycle itself
    wait_cnt(FD - 1);
    bus.fcw_l = 32'h3000_0000;
    bus.fcw_r = 32'h0800_0000;
    pulse_load();
    idle(2 * FD);

    // Phase clear requested mid-frame
    bus.amp = 8'd255;
    wait_cnt(100);
    bus.phase_clr = 1'b1;
    step();
    bus.phase_clr = 1'b0;
    idle(2 * FD);

    // Reset while the left sample is in the pipeline
    wait_cnt(2);
    async_reset();
    idle(2 * FD);

    // Randomised amp, loads, stray fcw changes and clears
    for (int i = 0; i < 8 * FD; i++) begin
      bus.amp = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) begin
        bus.fcw_l = $urandom;
        bus.fcw_r = $urandom;
      end
      bus.fcw_load  = ($urandom_range(0, 299) == 0);
      bus.phase_clr = ($urandom_range(0, 699) == 0);
      step();
    end
    bus.fcw_load  = 1'b0;
    bus.phase_clr = 1'b0;

    wait_cnt(FD / 2 + 10);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
